// File: rtl/wb_arbiter_pkg.sv
// Shared CPU write-back definitions: register/data widths and arbiter FSM encoding.
package wb_arbiter_pkg;

  localparam int REG_W  = 6;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-return buffer: FIFO of {rd, data} with per-entry valid bits that can be
// cleared by destination register (WAW kill). Killed entries stay in place and
// are popped by the arbiter without a write.
module wb_load_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [REG_W-1:0]        push_rd,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  input  logic                    kill,
  input  logic [REG_W-1:0]        kill_rd,
  output logic                    head_valid,
  output logic [REG_W-1:0]        head_rd,
  output logic [DATA_W-1:0]       head_data,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_W-1:0]  rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Entry payload storage; only the valid bits need a reset.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and valid bits; later assignments override the kill sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && vld[i] && (rd_mem[i] == kill_rd)) vld[i] <= 1'b0;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != '0) && vld[rd_ptr];
  assign head_rd    = rd_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign full       = (count == CW'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back has priority, then
// the buffered load head, then a direct bypass of a load when the buffer is empty.
// A starved head forces a pipeline bubble via the registered stall request.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid,
  input  logic [REG_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [REG_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]       mem_data,
  output logic                    rf_we,
  output logic [REG_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic                    stall,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_state_e         state;
  logic [SW-1:0]     starve;
  logic              full;
  logic              head_valid;
  logic [REG_W-1:0]  head_rd;
  logic [DATA_W-1:0] head_data;
  logic              accept;
  logic              load_killed;
  logic              head_present;
  logic              grant_head;
  logic              drop_head;
  logic              bypass;
  logic              push;
  logic              pop;
  logic [CW-1:0]     count_next;
  logic              next_empty;

  // Ready depends only on occupancy, never on mem_valid.
  assign mem_ready    = ~full;
  assign accept       = mem_valid & mem_ready;
  // A load accepted under a same-rd pipeline write is already stale: drop it.
  assign load_killed  = alu_valid & (mem_rd == alu_rd);
  assign head_present = (count != '0);
  assign grant_head   = ~alu_valid & head_valid;
  // A killed head leaves without using the write port, even while the ALU writes.
  assign drop_head    = head_present & ~head_valid;
  assign bypass       = ~alu_valid & ~head_present & accept;
  assign push         = accept & ~load_killed & ~bypass;
  assign pop          = grant_head | drop_head;
  assign count_next   = count + CW'(push) - CW'(pop);
  assign next_empty   = (count_next == '0);

  wb_load_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_rd    (mem_rd),
    .push_data  (mem_data),
    .pop        (pop),
    .kill       (alu_valid),
    .kill_rd    (alu_rd),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .full       (full),
    .count      (count)
  );

  // Registered write port: granted write lands one edge later, address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (alu_valid) begin
      rf_we    <= 1'b1;
      rf_waddr <= alu_rd;
      rf_wdata <= alu_data;
    end else if (grant_head) begin
      rf_we    <= 1'b1;
      rf_waddr <= head_rd;
      rf_wdata <= head_data;
    end else if (bypass) begin
      rf_we    <= 1'b1;
      rf_waddr <= mem_rd;
      rf_wdata <= mem_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Occupancy/starvation FSM with registered stall request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      stall  <= 1'b0;
      starve <= '0;
    end else begin
      case (state)
        IDLE: begin
          starve <= '0;
          if (push) state <= PEND;
        end
        PEND: begin
          if (pop) begin
            starve <= '0;
            if (next_empty) state <= IDLE;
          end else if (alu_valid && head_valid) begin
            if (starve == SW'(STARVE_LIMIT - 1)) begin
              starve <= '0;
              stall  <= 1'b1;
              state  <= FORCE;
            end else begin
              starve <= starve + 1'b1;
            end
          end
        end
        FORCE: begin
          if (grant_head || next_empty) begin
            starve <= '0;
            stall  <= 1'b0;
            state  <= next_empty ? IDLE : PEND;
          end else if (pop) begin
            starve <= '0;
          end
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter (DEPTH=2, STARVE_LIMIT=4): table of per-cycle vectors
// with hand-derived expected outputs fed through a scoreboard queue, plus
// directed reset sequences.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [5:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [5:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rf_we;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall;
  logic [1:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        av;
    logic [5:0]  ard;
    logic [31:0] adata;
    logic        mv;
    logic [5:0]  mrd;
    logic [31:0] mdata;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [1:0]  cnt;
    logic        rdy;
    logic        st;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[25];

  wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .stall     (stall),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic av, input logic [5:0] ard, input logic [31:0] adata,
                               input logic mv, input logic [5:0] mrd, input logic [31:0] mdata,
                               input logic we, input logic [5:0] wa, input logic [31:0] wd,
                               input logic [1:0] cnt, input logic rdy, input logic st);
    vec_t v;
    v.av = av; v.ard = ard; v.adata = adata;
    v.mv = mv; v.mrd = mrd; v.mdata = mdata;
    v.we = we; v.wa = wa; v.wd = wd;
    v.cnt = cnt; v.rdy = rdy; v.st = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.adata;
    mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.mdata;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, " rf_we"},     32'(rf_we),     32'(e.we));
    chk({tag, " rf_waddr"},  32'(rf_waddr),  32'(e.wa));
    chk({tag, " rf_wdata"},  rf_wdata,       e.wd);
    chk({tag, " count"},     32'(count),     32'(e.cnt));
    chk({tag, " mem_ready"}, 32'(mem_ready), 32'(e.rdy));
    chk({tag, " stall"},     32'(stall),     32'(e.st));
  endtask

  initial begin
    //          av ard    adata         mv mrd    mdata         we wa     wd            cnt rdy st
    // single load bypass, then hold
    tbl[0]  = mkv(0, 6'd0,  32'h0,        1, 6'd5,  32'hDEADBEEF, 1, 6'd5,  32'hDEADBEEF, 0, 1, 0);
    tbl[1]  = mkv(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,        0, 6'd5,  32'hDEADBEEF, 0, 1, 0);
    // ALU and load together: ALU first, load next
    tbl[2]  = mkv(1, 6'd3,  32'h11,       1, 6'd7,  32'h22,       1, 6'd3,  32'h11,       1, 1, 0);
    tbl[3]  = mkv(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,        1, 6'd7,  32'h22,       0, 1, 0);
    tbl[4]  = mkv(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,        0, 6'd7,  32'h22,       0, 1, 0);
    // fill the buffer, third load held off until a pop
    tbl[5]  = mkv(1, 6'd1,  32'hA1,       1, 6'd8,  32'h88,       1, 6'd1,  32'hA1,       1, 1, 0);
    tbl[6]  = mkv(1, 6'd2,  32'hA2,       1, 6'd9,  32'h99,       1, 6'd2,  32'hA2,       2, 0, 0);
    tbl[7]  = mkv(1, 6'd10, 32'hA3,       1, 6'd12, 32'hCC,       1, 6'd10, 32'hA3,       2, 0, 0);
    tbl[8]  = mkv(0, 6'd0,  32'h0,        1, 6'd12, 32'hCC,       1, 6'd8,  32'h88,       1, 1, 0);
    tbl[9]  = mkv(0, 6'd0,  32'h0,        1, 6'd12, 32'hCC,       1, 6'd9,  32'h99,       1, 1, 0);
    tbl[10] = mkv(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,        1, 6'd12, 32'hCC,       0, 1, 0);
    // WAW kill of a buffered load
    tbl[11] = mkv(1, 6'd11, 32'h77,       1, 6'd4,  32'h44,       1, 6'd11, 32'h77,       1, 1, 0);
    tbl[12] = mkv(1, 6'd4,  32'h55,       0, 6'd0,  32'h0,        1, 6'd4,  32'h55,       1, 1, 0);
    tbl[13] = mkv(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,        0, 6'd4,  32'h55,       0, 1, 0);
    tbl[14] = mkv(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,        0, 6'd4,  32'h55,       0, 1, 0);
    // WAW kill of a load accepted in the same cycle
    tbl[15] = mkv(1, 6'd6,  32'h66,       1, 6'd6,  32'h67,       1, 6'd6,  32'h66,       0, 1, 0);
    tbl[16] = mkv(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,        0, 6'd6,  32'h66,       0, 1, 0);
    // starvation: four lost cycles force a stall, ALU still wins while stalled
    tbl[17] = mkv(1, 6'd20, 32'h20,       1, 6'd21, 32'h21,       1, 6'd20, 32'h20,       1, 1, 0);
    tbl[18] = mkv(1, 6'd22, 32'h22,       0, 6'd0,  32'h0,        1, 6'd22, 32'h22,       1, 1, 0);
    tbl[19] = mkv(1, 6'd23, 32'h23,       0, 6'd0,  32'h0,        1, 6'd23, 32'h23,       1, 1, 0);
    tbl[20] = mkv(1, 6'd24, 32'h24,       0, 6'd0,  32'h0,        1, 6'd24, 32'h24,       1, 1, 0);
    tbl[21] = mkv(1, 6'd25, 32'h25,       0, 6'd0,  32'h0,        1, 6'd25, 32'h25,       1, 1, 1);
    tbl[22] = mkv(1, 6'd26, 32'h26,       0, 6'd0,  32'h0,        1, 6'd26, 32'h26,       1, 1, 1);
    tbl[23] = mkv(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,        1, 6'd21, 32'h21,       0, 1, 0);
    tbl[24] = mkv(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,        0, 6'd21, 32'h21,       0, 1, 0);

    // Reset state, with a load already presented while in reset.
    rst_n = 1'b1;
    drive_idle();
    #1 rst_n = 1'b0;
    mem_valid = 1'b1; mem_rd = 6'h3F; mem_data = 32'h12345678;
    #1;
    chk("reset rf_we",     32'(rf_we),     32'd0);
    chk("reset rf_waddr",  32'(rf_waddr),  32'd0);
    chk("reset rf_wdata",  rf_wdata,       32'd0);
    chk("reset stall",     32'(stall),     32'd0);
    chk("reset count",     32'(count),     32'd0);
    chk("reset mem_ready", 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    chk("in-reset rf_we", 32'(rf_we), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("release rf_we", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    chk("first write we",    32'(rf_we),    32'd1);
    chk("first write waddr", 32'(rf_waddr), 32'h3F);
    chk("first write wdata", rf_wdata,      32'h12345678);

    for (int i = 0; i < 25; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of operation with two loads buffered.
    step(mkv(1, 6'd30, 32'h30, 1, 6'd31, 32'h31, 1, 6'd30, 32'h30, 1, 1, 0), "fill0");
    step(mkv(1, 6'd32, 32'h32, 1, 6'd33, 32'h33, 1, 6'd32, 32'h32, 2, 0, 0), "fill1");
    @(negedge clk);
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst count",     32'(count),     32'd0);
    chk("midrst rf_we",     32'(rf_we),     32'd0);
    chk("midrst stall",     32'(stall),     32'd0);
    chk("midrst mem_ready", 32'(mem_ready), 32'd1);
    chk("midrst rf_waddr",  32'(rf_waddr),  32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post-rst%0d rf_we", k), 32'(rf_we), 32'd0);
      chk($sformatf("post-rst%0d count", k), 32'(count), 32'd0);
    end

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
